// File: rtl/uart_tx_feeder_if.sv
// Write-side bundle of the UART feeder: byte strobe in, FIFO status out.
// master is user logic, slave is the feeder.
interface uart_tx_feeder_if #(
  parameter int DEPTH_LOG2 = 4
);
  logic                wr_en;
  logic [7:0]          wr_data;
  logic                ovf_clr;
  logic                full;
  logic                empty;
  logic [DEPTH_LOG2:0] level;
  logic                overflow;

  modport master (
    output wr_en,
    output wr_data,
    output ovf_clr,
    input  full,
    input  empty,
    input  level,
    input  overflow
  );

  modport slave (
    input  wr_en,
    input  wr_data,
    input  ovf_clr,
    output full,
    output empty,
    output level,
    output overflow
  );
endinterface

// File: rtl/uart_tx_feeder.sv
// Byte FIFO plus slot pacer for a UART transmitter with no busy output.
// Frame starts are uart_en rises spaced exactly SLOT_CYCLES apart.
module uart_tx_feeder #(
  parameter int DEPTH_LOG2  = 4,
  parameter int SLOT_CYCLES = 256
) (
  input  logic            sys_clk,
  input  logic            sys_rst,
  uart_tx_feeder_if.slave wr,
  output logic            busy,
  output logic            uart_en,
  output logic [7:0]      uart_din
);
  localparam int DEPTH = 1 << DEPTH_LOG2;
  localparam int LW    = DEPTH_LOG2 + 1;
  localparam int CW    = $clog2(SLOT_CYCLES);

  localparam logic [CW-1:0] LAST    = CW'(SLOT_CYCLES - 1);
  localparam logic [CW-1:0] STR_END = CW'(1);
  localparam logic [LW-1:0] FULL_N  = LW'(DEPTH);

  typedef enum logic [1:0] {
    IDLE,
    STROBE,
    WAIT
  } state_t;

  state_t state_q;
  state_t state_d;

  logic [CW-1:0]         cnt_q;
  logic [CW-1:0]         cnt_d;
  logic [7:0]            mem [DEPTH];
  logic [DEPTH_LOG2-1:0] wr_ptr;
  logic [DEPTH_LOG2-1:0] rd_ptr;
  logic [LW-1:0]         count_q;
  logic [LW-1:0]         count_d;
  logic                  full_q;
  logic                  empty_q;
  logic                  ovf_q;
  logic                  push;
  logic                  pop;

  assign push    = wr.wr_en & ~full_q;
  assign count_d = count_q + LW'(push) - LW'(pop);

  assign wr.full     = full_q;
  assign wr.empty    = empty_q;
  assign wr.level    = count_q;
  assign wr.overflow = ovf_q;

  assign busy = (state_q != IDLE);

  always_ff @(posedge sys_clk) begin
    if (push) begin
      mem[wr_ptr] <= wr.wr_data;
    end
  end

  always_ff @(posedge sys_clk) begin
    if (sys_rst) begin
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      count_q <= '0;
      full_q  <= 1'b0;
      empty_q <= 1'b1;
    end else begin
      if (push) begin
        wr_ptr <= wr_ptr + 1'b1;
      end
      if (pop) begin
        rd_ptr <= rd_ptr + 1'b1;
      end
      count_q <= count_d;
      full_q  <= (count_d == FULL_N);
      empty_q <= (count_d == '0);
    end
  end

  // a dropped write beats a same-cycle clear
  always_ff @(posedge sys_clk) begin
    if (sys_rst) begin
      ovf_q <= 1'b0;
    end else if (wr.wr_en && full_q) begin
      ovf_q <= 1'b1;
    end else if (wr.ovf_clr) begin
      ovf_q <= 1'b0;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    pop     = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (!empty_q) begin
          pop     = 1'b1;
          cnt_d   = '0;
          state_d = STROBE;
        end
      end
      STROBE: begin
        cnt_d = cnt_q + CW'(1);
        if (cnt_q == STR_END) begin
          state_d = WAIT;
        end
      end
      WAIT: begin
        if (cnt_q == LAST) begin
          cnt_d = '0;
          if (!empty_q) begin
            pop     = 1'b1;
            state_d = STROBE;
          end else begin
            state_d = IDLE;
          end
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      default: begin
        state_d = IDLE;
        cnt_d   = '0;
      end
    endcase
  end

  // uart_en is registered so it rises together with the STROBE entry
  always_ff @(posedge sys_clk) begin
    if (sys_rst) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      uart_en  <= 1'b0;
      uart_din <= 8'h00;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      uart_en <= (state_d == STROBE);
      if (pop) begin
        uart_din <= mem[rd_ptr];
      end
    end
  end
endmodule
